delay_sum: RTL and testbench
============================

# delay_sum

Consumer end of the per-microphone delay lines in the beamforming path. It captures the delayed PCM samples from all channels on a sample strobe, accumulates them one channel per clock, and presents the registered delay-and-sum beam sample with a one-cycle valid pulse to the downstream decimation and output stage.

## Interface
- `NUM_CH`, default 4: number of delay-line channels summed (≥2, power of two).
- `DATA_W`, default 19: width of each signed two's-complement PCM sample.
- `SUM_W` (localparam): `DATA_W + log2(NUM_CH)`, which is 21 at the defaults.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `sample_valid` input, 1 bit: one-cycle strobe marking that `ch_data` holds a new set of delayed samples.
- `ch_data` input, `NUM_CH*DATA_W` bits: flattened delayed samples; channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `sum_out` output, `SUM_W` bits: signed beam sample, registered and held until the next result.
- `sum_valid` output, 1 bit: one-cycle pulse when `sum_out` updates.
- `busy` output, 1 bit: high while an accumulation is in progress.
- `dropped` output, 1 bit: sticky flag for a strobe that was ignored; cleared only by reset.

## Operation
- States:
  - IDLE: waiting for a strobe.
  - ACC: adding one channel per cycle.
  - DONE: publishing the result.
- IDLE to ACC: on `sample_valid`.
  - Latch all of `ch_data` into a capture register.
  - Clear the accumulator.
  - Set the channel index to 0.
- ACC:
  - Each cycle, add the channel at the current index to the accumulator, sign-extended to `SUM_W`.
  - Increment the index.
  - After channel `NUM_CH-1` is added, go to DONE.
- DONE:
  - Load `sum_out` from the accumulator and pulse `sum_valid`.
  - Return to IDLE in the same cycle. DONE is a single-cycle state.
- Arithmetic is full precision. `SUM_W` bits cannot overflow for `NUM_CH` inputs of `DATA_W` bits.
  - No saturation and no scaling.
  - The sum is independent of the order channels are added.
- A `sample_valid` arriving in ACC is ignored.
  - The capture register is not disturbed.
  - `dropped` is set to 1.
- A `sample_valid` arriving in DONE is accepted normally. DONE counts as IDLE for acceptance.
- `ch_data` is sampled only in the accept cycle. Changes afterwards do not affect the result in progress.
- Reset values, including reset asserted mid-accumulation:
  - State IDLE.
  - `sum_out` = 0, `sum_valid` = 0, `busy` = 0, `dropped` = 0.
  - Accumulator, capture register and index all 0.
  - Any partial sum is discarded, with no `sum_valid` pulse.

## Timing
- Strobe accepted at edge T:
  - `busy` = 1 during cycles T+1 through T+NUM_CH.
  - `sum_valid` = 1 and `sum_out` valid in cycle T+NUM_CH+1, with `busy` = 0 in that cycle.
- Latency from strobe to `sum_valid` is `NUM_CH+1` cycles, which is 5 at the defaults.
- Minimum strobe spacing for no drops is `NUM_CH+1` cycles.
  - A strobe coincident with `sum_valid` is accepted.
- `sum_out` changes only in the `sum_valid` cycle and holds otherwise.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `DELAY_SUM_MASK_EN`.
- Defined:
  - Adds input `ch_mask`, `NUM_CH` bits wide, sampled together with `ch_data` at accept.
  - A channel whose mask bit is 0 contributes 0 to the sum.
  - Latency is unchanged; every channel slot still takes one ACC cycle.
- Not defined:
  - The port is absent.
  - All channels are always summed.

## Test plan
- Reset, then `sample_valid` with channels {1, 2, 3, 4}: `busy` is high for 4 cycles, then `sum_out` = 10 with a one-cycle `sum_valid`, 5 cycles after the strobe.
- Channels {-262144, -262144, -262144, -262144} (the most-negative 19-bit value): `sum_out` = -1048576, the 21-bit minimum, with no wrap. Channels {262143 ×4}: `sum_out` = 1048572.
- Mixed signs {100, -300, 50, 150}: `sum_out` = 0. Then drive `ch_data` to all 7 one cycle after the strobe: the result is still 0.
- Second strobe 2 cycles after the first: the first result is delivered correctly, the second strobe is ignored, and `dropped` = 1 and stays 1. A strobe in the `sum_valid` cycle: accepted, and its result appears 5 cycles later.
- Assert `rst` during the third ACC cycle: all outputs are 0 immediately, no `sum_valid` appears afterwards, and the next strobe {5, 5, 5, 5} yields 20.
- With `DELAY_SUM_MASK_EN` defined, `ch_mask` = 4'b0101 and channels {10, 20, 30, 40}: `sum_out` = 40 (channels 0 and 2), with latency still 5.

Source files
------------

// File: rtl/delay_sum_if.sv
// delay_sum_if: bundle between the delay-line bank and the delay-and-sum block.
// Optional channel mask is present only when DELAY_SUM_MASK_EN is defined.
//
// Handshake: there is no ready. sample_valid is a one-cycle strobe, and the
// consumer takes ch_data (and ch_mask) only in the cycle it accepts the
// strobe. A strobe that arrives while busy is high is ignored and raises the
// sticky dropped flag. sum_valid is a one-cycle pulse in the cycle sum_out
// takes its new value. sum_out then holds until the next pulse.
interface delay_sum_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 19
) ();
  localparam int SUM_W = DATA_W + $clog2(NUM_CH);

  logic                     sample_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
`ifdef DELAY_SUM_MASK_EN
  logic [NUM_CH-1:0]        ch_mask;
`endif
  logic [SUM_W-1:0]         sum_out;
  logic                     sum_valid;
  logic                     busy;
  logic                     dropped;

  // Producer side: drives the strobe and samples, observes the result.
  modport master (
    output sample_valid,
    output ch_data,
`ifdef DELAY_SUM_MASK_EN
    output ch_mask,
`endif
    input  sum_out,
    input  sum_valid,
    input  busy,
    input  dropped
  );

  // Consumer side: the delay_sum block itself.
  modport slave (
    input  sample_valid,
    input  ch_data,
`ifdef DELAY_SUM_MASK_EN
    input  ch_mask,
`endif
    output sum_out,
    output sum_valid,
    output busy,
    output dropped
  );
endinterface

// File: rtl/delay_sum.sv
// delay_sum: captures one set of delayed PCM samples per strobe, adds them
// one channel per clock at full precision, and publishes the registered
// beam sample with a one-cycle valid pulse.
// Optional build macro: DELAY_SUM_MASK_EN adds a per-channel mask that is
// captured with the samples. A masked channel contributes zero but still
// uses its accumulation slot, so latency does not depend on the mask.
module delay_sum #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 19
) (
  input  logic        clk,
  input  logic        rst,
  delay_sum_if.slave  bus,
  output logic [1:0]  o_dbg_state
);
  localparam int SUM_W = DATA_W + $clog2(NUM_CH);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;

  logic signed [DATA_W-1:0] r_cap [NUM_CH];
`ifdef DELAY_SUM_MASK_EN
  logic [NUM_CH-1:0]        r_mask;
`endif
  logic signed [SUM_W-1:0]  r_acc;
  logic [IDX_W-1:0]         r_idx;
  logic signed [SUM_W-1:0]  r_sum_out;
  logic                     r_sum_valid;
  logic                     r_busy;
  logic                     r_dropped;

  logic                     w_accept;
  logic                     w_drop;
  logic                     w_last;
  logic signed [DATA_W-1:0] w_ch;
  logic signed [SUM_W-1:0]  w_ch_ext;
  logic signed [SUM_W-1:0]  w_acc_next;

  // Select the captured channel at the current index; masked channels add zero.
  always_comb begin
    w_ch = r_cap[r_idx];
`ifdef DELAY_SUM_MASK_EN
    if (!r_mask[r_idx]) begin
      w_ch = '0;
    end
`endif
  end

  // Sign-extend the selected sample and form the next accumulator value.
  always_comb begin
    w_ch_ext   = {{(SUM_W-DATA_W){w_ch[DATA_W-1]}}, w_ch};
    w_acc_next = r_acc + w_ch_ext;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic plus accept/drop/last-channel decodes. DONE accepts
  // a strobe just like IDLE, which makes back-to-back strobes NUM_CH+1 apart.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ACC;
        end
      end
      S_ACC: begin
        w_drop = bus.sample_valid;
        if (r_idx == LAST_IDX) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.sample_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_ACC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Capture register, mask and channel index; loaded only on accept so later
  // input changes or ignored strobes cannot disturb a sum in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_cap[k] <= '0;
      end
`ifdef DELAY_SUM_MASK_EN
      r_mask <= '0;
`endif
      r_idx <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NUM_CH; k++) begin
        r_cap[k] <= bus.ch_data[k*DATA_W +: DATA_W];
      end
`ifdef DELAY_SUM_MASK_EN
      r_mask <= bus.ch_mask;
`endif
      r_idx <= '0;
    end else if (r_state == S_ACC) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Accumulator: cleared on accept, one channel added per ACC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (r_state == S_ACC) begin
      r_acc <= w_acc_next;
    end
  end

  // Result register and valid pulse. The last add feeds sum_out directly so
  // the result is visible in the DONE cycle with sum_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_out   <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_sum_valid <= w_last;
      if (w_last) begin
        r_sum_out <= w_acc_next;
      end
    end
  end

  // Status flags: busy mirrors the ACC state one cycle ahead, dropped is sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_busy <= (w_state_next == S_ACC);
      if (w_drop) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign bus.sum_out   = r_sum_out;
  assign bus.sum_valid = r_sum_valid;
  assign bus.busy      = r_busy;
  assign bus.dropped   = r_dropped;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_delay_sum.sv
// tb_delay_sum: directed and random strobes against delay_sum with a
// scoreboard queue of expected beam samples.
module tb_delay_sum;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 19;
  localparam int SUM_W  = DATA_W + $clog2(NUM_CH);
  localparam logic [NUM_CH-1:0] ALL_CH = '1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_pushed = 0;
  int n_popped = 0;
  logic [SUM_W-1:0] exp_q[$];
  logic [SUM_W-1:0] exp_v;

  delay_sum_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  delay_sum #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // Clock and overall time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no end expected end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] pack4(input int a, input int b,
                                                     input int c, input int d);
    logic [DATA_W-1:0] ea, eb, ec, ed;
    ea = a[DATA_W-1:0];
    eb = b[DATA_W-1:0];
    ec = c[DATA_W-1:0];
    ed = d[DATA_W-1:0];
    return {ed, ec, eb, ea};
  endfunction

  // Reference: full-precision signed sum of the unmasked channels.
  function automatic logic [SUM_W-1:0] model(input logic [NUM_CH*DATA_W-1:0] d,
                                             input logic [NUM_CH-1:0] m);
    logic signed [SUM_W-1:0]  acc;
    logic signed [DATA_W-1:0] s;
    acc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = d[k*DATA_W +: DATA_W];
      if (m[k]) acc = acc + s;
    end
    return acc;
  endfunction

  // Scoreboard: every sum_valid pulse pops and compares one expected value.
  always @(negedge clk) begin
    if (!rst && bus.sum_valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() > 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: got sum_valid=1 with sum_out=%0d expected no pending result",
               $signed(bus.sum_out));
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_popped++;
        n_checks++;
        assert (bus.sum_out === exp_v) else begin
          n_errors++;
          $error("FAIL sb_sum: got %0d expected %0d", $signed(bus.sum_out), $signed(exp_v));
        end
      end
    end
  end

  // Drive one strobe at the current negedge and follow it cycle by cycle.
  // corrupt_at: cycle after which ch_data is overwritten with all 7s.
  // drop_at:    cycle in which a second (ignored) strobe is driven.
  // abort_at:   cycle in which rst is asserted mid-accumulation.
  // Returns at the negedge of the sum_valid cycle (or right after abort).
  task automatic strobe_run(input string tag, input logic [NUM_CH*DATA_W-1:0] data,
                            input logic [NUM_CH-1:0] mask, input bit push,
                            input int exp_lit, input int corrupt_at,
                            input int drop_at, input int abort_at);
    bus.ch_data      = data;
`ifdef DELAY_SUM_MASK_EN
    bus.ch_mask      = mask;
`endif
    bus.sample_valid = 1'b1;
    if (push) begin
      exp_q.push_back(model(data, mask));
      n_pushed++;
    end
    for (int c = 1; c <= NUM_CH + 1; c++) begin
      @(negedge clk);
      if (c <= NUM_CH) begin
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_novalid"}, bus.sum_valid, 0);
        if (c == 1) chk({tag, "_state_acc"}, dbg_state, 1);
      end else begin
        chk({tag, "_valid"}, bus.sum_valid, 1);
        chk({tag, "_busy_low"}, bus.busy, 0);
        chk({tag, "_sum"}, $signed(bus.sum_out), exp_lit);
      end
      if (drop_at > 0 && c == drop_at + 1) chk({tag, "_dropped"}, bus.dropped, 1);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        chk({tag, "_rst_sum"}, $signed(bus.sum_out), 0);
        chk({tag, "_rst_valid"}, bus.sum_valid, 0);
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_dropped"}, bus.dropped, 0);
        chk({tag, "_rst_state"}, dbg_state, 0);
        bus.sample_valid = 1'b0;
        return;
      end
      bus.sample_valid = (c == drop_at);
      if (c == drop_at) bus.ch_data = ~data;
      if (c == corrupt_at) bus.ch_data = {NUM_CH{DATA_W'(7)}};
    end
  endtask

  // Directed sequence followed by a few random strobes.
  initial begin
    logic [NUM_CH*DATA_W-1:0] rd;
    logic [NUM_CH-1:0]        rm;
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.ch_data      = '0;
`ifdef DELAY_SUM_MASK_EN
    bus.ch_mask      = '1;
`endif
    repeat (3) @(negedge clk);
    chk("reset_sum", $signed(bus.sum_out), 0);
    chk("reset_valid", bus.sum_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_dropped", bus.dropped, 0);
    chk("reset_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);

    strobe_run("basic", pack4(1, 2, 3, 4), ALL_CH, 1'b1, 10, 0, 0, 0);
    @(negedge clk);
    chk("basic_pulse_end", bus.sum_valid, 0);
    chk("basic_hold", $signed(bus.sum_out), 10);
    chk("basic_state_idle", dbg_state, 0);

    strobe_run("minneg", pack4(-262144, -262144, -262144, -262144), ALL_CH, 1'b1,
               -1048576, 0, 0, 0);
    strobe_run("maxpos", pack4(262143, 262143, 262143, 262143), ALL_CH, 1'b1,
               1048572, 0, 0, 0);
    strobe_run("mixed", pack4(100, -300, 50, 150), ALL_CH, 1'b1, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    chk("no_drop_yet", bus.dropped, 0);

    strobe_run("drop", pack4(11, 22, 33, 44), ALL_CH, 1'b1, 110, 0, 2, 0);
    strobe_run("coinc", pack4(5, 6, 7, 8), ALL_CH, 1'b1, 26, 0, 0, 0);
    chk("dropped_sticky", bus.dropped, 1);

    strobe_run("abort", pack4(9, 9, 9, 9), ALL_CH, 1'b0, 0, 0, 0, 3);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_valid", bus.sum_valid, 0);
    end
    strobe_run("after_rst", pack4(5, 5, 5, 5), ALL_CH, 1'b1, 20, 0, 0, 0);

`ifdef DELAY_SUM_MASK_EN
    strobe_run("mask", pack4(10, 20, 30, 40), 4'b0101, 1'b1, 40, 0, 0, 0);
`endif

    for (int i = 0; i < 6; i++) begin
      rd = pack4(int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144);
`ifdef DELAY_SUM_MASK_EN
      rm = NUM_CH'($urandom_range(0, 15));
`else
      rm = ALL_CH;
`endif
      strobe_run("rand", rd, rm, 1'b1, int'($signed(model(rd, rm))), 0, 0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    chk("sb_count", n_popped, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
